// File: rtl/fltadd_seq.sv
// fltadd_seq: multi-cycle FP16 add/subtract engine working on byte-wide data memory.
// It loads flt1 (BASE, BASE+1) and flt2 (BASE+2, BASE+3), both big-endian. It then
// aligns, adds and normalizes one bit per cycle, and writes the result to BASE+4/BASE+5.
// Rounding is truncation everywhere. Results that overflow saturate to the largest finite
// value, and exponent 31 on an input is treated as an ordinary exponent.
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   start       one-cycle request, accepted only in IDLE or DONE
//   mem_addr    byte address (registered)
//   mem_rd_data combinational read data for mem_addr
//   mem_wr_en   write strobe, high only in ST0/ST1 (registered)
//   mem_wr_data write data (registered)
//   busy        high in every state except IDLE and DONE (registered)
//   done        high in DONE until the next start or reset (registered)
module fltadd_seq #(
    parameter logic [7:0] BASE      = 8'd128,
    parameter int         MAX_SHIFT = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic [7:0] mem_addr,
    input  logic [7:0] mem_rd_data,
    output logic       mem_wr_en,
    output logic [7:0] mem_wr_data,
    output logic       busy,
    output logic       done
);

    typedef enum logic [3:0] {
        S_IDLE, S_LD0, S_LD1, S_LD2, S_LD3, S_UNPACK, S_ALIGN,
        S_ADD, S_NORM, S_PACK, S_ST0, S_ST1, S_DONE
    } state_t;

    localparam logic [5:0] MAX_SHIFT_C = 6'(MAX_SHIFT);

    state_t      state_r, state_next_s;
    logic [15:0] flt1_r, flt2_r, result_r;
    logic        sign_r, sub_r;
    logic [5:0]  e_r;
    logic [10:0] ma_r, mb_r;
    logic [4:0]  k_r;
    logic [11:0] s_r;

    logic [4:0]  exp1_s, exp2_s;
    logic [5:0]  e1_s, e2_s, ea_s, eb_s, diff_s;
    logic [10:0] m1_s, m2_s;
    logic        a_is_1_s;
    logic [4:0]  k_s;
    logic [11:0] sum_s, norm_s_s;
    logic [5:0]  norm_e_s;
    logic        norm_need_s, norm_more_s;
    logic [15:0] pack_s;

    // Unpack both operands and pick the larger magnitude as A; ties keep flt1 as A.
    always_comb begin
        exp1_s   = flt1_r[14:10];
        exp2_s   = flt2_r[14:10];
        e1_s     = (exp1_s == 5'd0) ? 6'd1 : {1'b0, exp1_s};
        e2_s     = (exp2_s == 5'd0) ? 6'd1 : {1'b0, exp2_s};
        m1_s     = {|exp1_s, flt1_r[9:0]};
        m2_s     = {|exp2_s, flt2_r[9:0]};
        a_is_1_s = (flt1_r[14:0] >= flt2_r[14:0]);
        if (a_is_1_s) begin
            ea_s = e1_s;
            eb_s = e2_s;
        end else begin
            ea_s = e2_s;
            eb_s = e1_s;
        end
        // The larger magnitude never has the smaller exponent, so this cannot wrap.
        diff_s = ea_s - eb_s;
        if (diff_s > MAX_SHIFT_C) begin
            k_s = MAX_SHIFT_C[4:0];
        end else begin
            k_s = diff_s[4:0];
        end
    end

    // Magnitude add/subtract; A is the larger operand, so a difference is never negative.
    always_comb begin
        if (sub_r) begin
            sum_s = {1'b0, ma_r} - {1'b0, mb_r};
        end else begin
            sum_s = {1'b0, ma_r} + {1'b0, mb_r};
        end
        norm_need_s = sum_s[11] | (~sum_s[10] & (e_r > 6'd1));
    end

    // One normalization step: a carry-out shifts right once, otherwise shift left
    // until the hidden bit is set or the exponent reaches the subnormal floor.
    always_comb begin
        if (s_r[11]) begin
            norm_s_s    = {1'b0, s_r[11:1]};
            norm_e_s    = e_r + 6'd1;
            norm_more_s = 1'b0;
        end else begin
            norm_s_s    = {s_r[10:0], 1'b0};
            norm_e_s    = e_r - 6'd1;
            norm_more_s = ~norm_s_s[10] & (norm_e_s > 6'd1);
        end
    end

    // Pack sign/exponent/fraction. Overflow saturates to the largest finite value,
    // and a clear hidden bit selects the subnormal encoding.
    always_comb begin
        if (e_r > 6'd30) begin
            pack_s = {sign_r, 15'h7BFF};
        end else if (!s_r[10]) begin
            pack_s = {sign_r, 5'd0, s_r[9:0]};
        end else begin
            pack_s = {sign_r, e_r[4:0], s_r[9:0]};
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_next_s = S_LD0;
                end else begin
                    state_next_s = state_r;
                end
            end
            S_LD0:    state_next_s = S_LD1;
            S_LD1:    state_next_s = S_LD2;
            S_LD2:    state_next_s = S_LD3;
            S_LD3:    state_next_s = S_UNPACK;
            S_UNPACK: begin
                if (k_s != 5'd0) begin
                    state_next_s = S_ALIGN;
                end else begin
                    state_next_s = S_ADD;
                end
            end
            S_ALIGN: begin
                if (k_r <= 5'd1) begin
                    state_next_s = S_ADD;
                end else begin
                    state_next_s = S_ALIGN;
                end
            end
            S_ADD: begin
                if (sum_s == 12'd0) begin
                    state_next_s = S_PACK;
                end else if (norm_need_s) begin
                    state_next_s = S_NORM;
                end else begin
                    state_next_s = S_PACK;
                end
            end
            S_NORM: begin
                if (norm_more_s) begin
                    state_next_s = S_NORM;
                end else begin
                    state_next_s = S_PACK;
                end
            end
            S_PACK:  state_next_s = S_ST0;
            S_ST0:   state_next_s = S_ST1;
            S_ST1:   state_next_s = S_DONE;
            default: state_next_s = S_IDLE;
        endcase
    end

    // State register and registered outputs, which are derived from the upcoming state so
    // they line up with it. The store data comes from pack_s while the state is PACK.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= S_IDLE;
            mem_addr    <= 8'd0;
            mem_wr_en   <= 1'b0;
            mem_wr_data <= 8'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            busy        <= (state_next_s != S_IDLE) && (state_next_s != S_DONE);
            done        <= (state_next_s == S_DONE);
            mem_wr_en   <= (state_next_s == S_ST0) || (state_next_s == S_ST1);
            case (state_next_s)
                S_LD0:   begin mem_addr <= BASE;         mem_wr_data <= 8'd0;          end
                S_LD1:   begin mem_addr <= BASE + 8'd1;  mem_wr_data <= 8'd0;          end
                S_LD2:   begin mem_addr <= BASE + 8'd2;  mem_wr_data <= 8'd0;          end
                S_LD3:   begin mem_addr <= BASE + 8'd3;  mem_wr_data <= 8'd0;          end
                S_ST0:   begin mem_addr <= BASE + 8'd4;  mem_wr_data <= pack_s[15:8];  end
                S_ST1:   begin mem_addr <= BASE + 8'd5;  mem_wr_data <= result_r[7:0]; end
                default: begin mem_addr <= 8'd0;         mem_wr_data <= 8'd0;          end
            endcase
        end
    end

    // Datapath registers, which are updated according to the current state.
    always_ff @(posedge clk) begin
        if (reset) begin
            flt1_r   <= 16'd0;
            flt2_r   <= 16'd0;
            result_r <= 16'd0;
            sign_r   <= 1'b0;
            sub_r    <= 1'b0;
            e_r      <= 6'd0;
            ma_r     <= 11'd0;
            mb_r     <= 11'd0;
            k_r      <= 5'd0;
            s_r      <= 12'd0;
        end else begin
            case (state_r)
                S_LD0: flt1_r[15:8] <= mem_rd_data;
                S_LD1: flt1_r[7:0]  <= mem_rd_data;
                S_LD2: flt2_r[15:8] <= mem_rd_data;
                S_LD3: flt2_r[7:0]  <= mem_rd_data;
                S_UNPACK: begin
                    sign_r <= a_is_1_s ? flt1_r[15] : flt2_r[15];
                    sub_r  <= flt1_r[15] ^ flt2_r[15];
                    e_r    <= ea_s;
                    ma_r   <= a_is_1_s ? m1_s : m2_s;
                    mb_r   <= a_is_1_s ? m2_s : m1_s;
                    k_r    <= k_s;
                end
                S_ALIGN: begin
                    mb_r <= {1'b0, mb_r[10:1]};
                    k_r  <= k_r - 5'd1;
                end
                S_ADD: begin
                    if (sum_s == 12'd0) begin
                        // An exact cancellation always gives positive zero.
                        s_r    <= 12'd0;
                        e_r    <= 6'd0;
                        sign_r <= 1'b0;
                    end else begin
                        s_r <= sum_s;
                    end
                end
                S_NORM: begin
                    s_r <= norm_s_s;
                    e_r <= norm_e_s;
                end
                S_PACK:  result_r <= pack_s;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fltadd_seq.sv
// tb_fltadd_seq: directed bench for fltadd_seq, built around an expected-result scoreboard.
// The bench models the data memory and supplies the operands combinationally. It captures
// the result bytes and counts write strobes. Expected results and latencies are pushed to a
// queue when an operation starts, and are popped and compared when done rises.
module tb_fltadd_seq;

    localparam logic [7:0] BASE = 8'd128;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] mem_addr;
    logic [7:0] mem_rd_data;
    logic       mem_wr_en;
    logic [7:0] mem_wr_data;
    logic       busy;
    logic       done;

    logic [7:0] opnd [0:3];
    logic [7:0] res_hi = 8'h00;
    logic [7:0] res_lo = 8'h00;
    int         wr_cnt = 0;
    int         bad_wr = 0;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic [15:0] res;
        int          lat;
    } exp_t;
    exp_t sb_q[$];

    fltadd_seq #(.BASE(BASE), .MAX_SHIFT(12)) dut (
        .clk(clk), .reset(reset), .start(start),
        .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Operand bytes are readable at BASE..BASE+3; every other address reads as zero.
    always_comb begin
        mem_rd_data = 8'h00;
        case (mem_addr)
            BASE:        mem_rd_data = opnd[0];
            BASE + 8'd1: mem_rd_data = opnd[1];
            BASE + 8'd2: mem_rd_data = opnd[2];
            BASE + 8'd3: mem_rd_data = opnd[3];
            default:     mem_rd_data = 8'h00;
        endcase
    end

    // Capture the written result bytes and count every write strobe.
    always @(posedge clk) begin
        if (mem_wr_en) begin
            wr_cnt <= wr_cnt + 1;
            if (mem_addr == BASE + 8'd4)      res_hi <= mem_wr_data;
            else if (mem_addr == BASE + 8'd5) res_lo <= mem_wr_data;
            else                              bad_wr <= bad_wr + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one operation. The start-sampling edge counts as edge 1. A second start pulse
    // is sent while busy when pulse_at > 0, and it must be ignored.
    task automatic run_op(input string tag, input logic [15:0] f1, input logic [15:0] f2,
                          input logic [15:0] exp_res, input int exp_lat, input int pulse_at);
        exp_t e;
        int   lat;
        int   wr0;
        opnd[0] = f1[15:8];
        opnd[1] = f1[7:0];
        opnd[2] = f2[15:8];
        opnd[3] = f2[7:0];
        e.res = exp_res;
        e.lat = exp_lat;
        sb_q.push_back(e);
        wr0 = wr_cnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 100) begin
            chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
            start = (lat == pulse_at);
            @(negedge clk);
            start = 1'b0;
            lat++;
        end
        e = sb_q.pop_front();
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_lat"}, lat, e.lat);
        chk({tag, "_res"}, {16'd0, res_hi, res_lo}, {16'd0, e.res});
        chk({tag, "_wrs"}, wr_cnt - wr0, 32'd2);
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int          wr_snap;
        logic [15:0] res_snap;
        reset = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) opnd[i] = 8'h00;
        @(negedge clk);
        @(negedge clk);
        chk("rst_addr", {24'd0, mem_addr}, 32'd0);
        chk("rst_wren", {31'd0, mem_wr_en}, 32'd0);
        chk("rst_wdata", {24'd0, mem_wr_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op("dbl", 16'h1A04, 16'h1A04, 16'h1E04, 11, 0);
        run_op("align2", 16'h4A10, 16'h4204, 16'h4B91, 12, 0);
        run_op("cancel", 16'h3C00, 16'hBC00, 16'h0000, 10, 0);
        run_op("lnorm", 16'h3C00, 16'hBA00, 16'h3400, 13, 0);
        run_op("sat", 16'h7BFF, 16'h7BFF, 16'h7BFF, 11, 0);
        run_op("subn", 16'h0001, 16'h0001, 16'h0002, 10, 0);
        run_op("k10", 16'h3C00, 16'h1400, 16'h3C01, 20, 0);
        run_op("kcap", 16'h0400, 16'h7800, 16'h7800, 22, 0);

        // Reset while in ALIGN: edge 6 after start enters ALIGN, then reset aborts.
        wr_snap  = wr_cnt;
        res_snap = {res_hi, res_lo};
        opnd[0] = 8'h4A; opnd[1] = 8'h10; opnd[2] = 8'h42; opnd[3] = 8'h04;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("abort_pre_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_wren", {31'd0, mem_wr_en}, 32'd0);
        repeat (3) @(negedge clk);
        chk("abort_idle", {31'd0, busy}, 32'd0);
        chk("abort_nowr", wr_cnt - wr_snap, 32'd0);
        chk("abort_bytes", {16'd0, res_hi, res_lo}, {16'd0, res_snap});
        run_op("after_rst", 16'h4A10, 16'h4204, 16'h4B91, 12, 0);

        // Extra start pulses while busy, one in a load state and one in ST1, are ignored.
        run_op("pulse_ld", 16'h3C00, 16'hBA00, 16'h3400, 13, 3);
        run_op("pulse_st", 16'h3C00, 16'hBA00, 16'h3400, 13, 12);
        @(negedge clk);
        chk("done_hold", {31'd0, done}, 32'd1);
        chk("stray_wr", bad_wr, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
